// File: rtl/e_gpu_conf_regs_if.sv
// rtl/e_gpu_conf_regs_if.sv - OBI configuration-port bundle for the e-GPU register block
//
// Purpose: groups the OBI request/grant/response signals of the e-GPU
// configuration port so the responder and its requester share one port.
// Signals:
//   req    requester -> responder  request
//   we     requester -> responder  1 = write, 0 = read
//   be     requester -> responder  byte enables
//   addr   requester -> responder  byte address
//   wdata  requester -> responder  write data
//   gnt    responder -> requester  grant
//   rvalid responder -> requester  response valid
//   rdata  responder -> requester  read data
interface e_gpu_conf_regs_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/e_gpu_conf_regs.sv
// rtl/e_gpu_conf_regs.sv - e-GPU configuration registers: OBI responder, kernel launch and run status
//
// Purpose: zero-wait-state OBI responder holding the kernel launch registers.
// Every request is granted in the cycle it is presented and answered exactly
// one cycle later. A write of START launches a kernel (one-cycle start_o
// pulse) when enabled and idle; done_i from the GPU core ends the run.
//
// Register map (word offset, addr[7:2] decoded, upper/lower bits ignored):
//   0x00 CTRL        RW   bit0 enable (writing 0 aborts a running kernel)
//   0x04 START       WO   bit0 = 1 launches, reads 0
//   0x08 STATUS          bit0 busy (RO), bit1 done (write 1 to clear)
//   0x0C KERNEL_PC   RW
//   0x10 NUM_GROUPS  RW   [NGRP_W-1:0], upper bits read 0
//   0x14 BUSY_CYCLES RO   only when E_GPU_CONF_PERF_EN is defined
//
// Optional feature macro: E_GPU_CONF_PERF_EN adds the saturating busy-cycle
// counter at 0x14. Without it 0x14 is unmapped and no counter exists.
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   rst_i         asynchronous active-high reset
//   obi           OBI responder side (e_gpu_conf_regs_if.slave)
//   enable_o      CTRL.enable
//   start_o       one-cycle kernel launch pulse
//   kernel_pc_o   KERNEL_PC
//   num_groups_o  NUM_GROUPS
//   done_i        GPU run complete, one-cycle pulse
module e_gpu_conf_regs #(
    parameter logic [31:0] PC_RST_VAL = 32'h0000_0000,
    parameter int          NGRP_W     = 16,
    parameter int          PERF_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    e_gpu_conf_regs_if.slave      obi,
    output logic                  enable_o,
    output logic                  start_o,
    output logic [31:0]           kernel_pc_o,
    output logic [NGRP_W-1:0]     num_groups_o,
    input  logic                  done_i
);

    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_START  = 6'd1;
    localparam logic [5:0] IDX_STATUS = 6'd2;
    localparam logic [5:0] IDX_PC     = 6'd3;
    localparam logic [5:0] IDX_NGRP   = 6'd4;
    localparam logic [5:0] IDX_PERF   = 6'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } run_state_t;

    run_state_t          state_q, state_d;
    logic                enable_q;
    logic                done_q, done_d;
    logic                start_q;
    logic [31:0]         pc_q;
    logic [NGRP_W-1:0]   ngrp_q;
    logic                rvalid_q;
    logic [31:0]         rdata_q;

    logic                busy;
    logic                rd_acc;
    logic                wr_acc;
    logic [5:0]          idx;
    logic                ctrl_wr;
    logic                abort;
    logic                launch;
    logic                w1c_done;
    logic                finish;
    logic [31:0]         rd_val;
    logic [31:0]         pc_merged;
    logic [31:0]         ngrp_merged;
    logic [31:0]         perf_rd;

    // Only the word index is decoded; the remaining address bits alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{obi.addr[31:8], obi.addr[1:0]};

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                r[8*k +: 8] = new_val[8*k +: 8];
            end
        end
        return r;
    endfunction

    // Grant is unconditional, so a request is accepted in the cycle it appears.
    assign obi.gnt = obi.req;
    assign rd_acc  = obi.req && !obi.we;
    assign wr_acc  = obi.req &&  obi.we;
    assign idx     = obi.addr[7:2];

    assign busy     = (state_q == ST_BUSY);
    assign ctrl_wr  = wr_acc && (idx == IDX_CTRL) && obi.be[0];
    assign abort    = ctrl_wr && !obi.wdata[0];
    assign launch   = wr_acc && (idx == IDX_START) && obi.be[0] && obi.wdata[0]
                      && enable_q && !busy;
    assign w1c_done = wr_acc && (idx == IDX_STATUS) && obi.be[0] && obi.wdata[1];
    // A completion pulse outside a run is stale and must not set done.
    assign finish   = done_i && busy;

    assign pc_merged   = be_merge(pc_q, obi.wdata, obi.be);
    assign ngrp_merged = be_merge(32'(ngrp_q), obi.wdata, obi.be);

    // Run state: launch only from idle; completion or abort return to idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (finish || abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A completion arriving with a clear request leaves done set.
        if (launch) begin
            done_d = 1'b0;
        end else if (finish) begin
            done_d = 1'b1;
        end else if (w1c_done) begin
            done_d = 1'b0;
        end
    end

`ifdef E_GPU_CONF_PERF_EN
    logic [PERF_W-1:0] perf_q;

    // Counts cycles spent busy in the current/last run; restarts on launch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (launch) begin
            perf_q <= '0;
        end else if (busy && (perf_q != {PERF_W{1'b1}})) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_rd = 32'(perf_q);
`else
    logic [PERF_W-1:0] unused_perf_w;
    assign unused_perf_w = '0;
    assign perf_rd       = 32'h0;
`endif

    always_comb begin
        rd_val = 32'h0;
        case (idx)
            IDX_CTRL:   rd_val = {31'h0, enable_q};
            IDX_STATUS: rd_val = {30'h0, done_q, busy};
            IDX_PC:     rd_val = pc_q;
            IDX_NGRP:   rd_val = 32'(ngrp_q);
            IDX_PERF:   rd_val = perf_rd;
            default:    rd_val = 32'h0;
        endcase
    end

    // Read data is captured at the accept edge, so a read issued right after
    // a write sees the newly written value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            pc_q     <= PC_RST_VAL;
            ngrp_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            done_q   <= done_d;
            start_q  <= launch;
            rvalid_q <= obi.req;
            rdata_q  <= rd_acc ? rd_val : 32'h0;
            if (ctrl_wr) begin
                enable_q <= obi.wdata[0];
            end
            if (wr_acc && (idx == IDX_PC)) begin
                pc_q <= pc_merged;
            end
            if (wr_acc && (idx == IDX_NGRP)) begin
                ngrp_q <= ngrp_merged[NGRP_W-1:0];
            end
        end
    end

    assign obi.rvalid   = rvalid_q;
    assign obi.rdata    = rdata_q;
    assign enable_o     = enable_q;
    assign start_o      = start_q;
    assign kernel_pc_o  = pc_q;
    assign num_groups_o = ngrp_q;

endmodule
